mult_share_arbiter: RTL
=======================

MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: req0  input  1  requester 0 requests a multiply.
REQ-004 SHALL have port: a0, b0  input  4 each  requester 0 operands, unsigned.
REQ-005 SHALL have port: gnt0  output  1  one-cycle pulse; requester 0 operands captured.
REQ-006 SHALL have ports: req1, a1, b1, gnt1, identical in meaning to requester 0.
REQ-007 SHALL have port: out  output  8  registered unsigned product.
REQ-008 SHALL have port: out_valid  output  1  out holds an unconsumed result.
REQ-009 SHALL have port: out_id  output  1  requester that owns out (0 or 1).
REQ-010 SHALL have port: out_ready  input  1  consumer accepts out this cycle.

Function
REQ-011 SHALL compute the product with one internal fourbit_multiplier instance fed only from the operand registers op_a[3:0] and op_b[3:0].
REQ-012 SHALL implement FSM states IDLE, MUL and HOLD.
REQ-013 IDLE, at least one req high at the edge: latch the winner's operands into op_a/op_b and its index into owner; set the winner's gnt high for exactly the next cycle; go to MUL.
REQ-014 IDLE, no req high: stay in IDLE; gnt0 and gnt1 low.
REQ-015 MUL: at the next edge, load out with op_a*op_b (full 8 bits, no truncation); set out_valid=1 and out_id=owner; go to HOLD.
REQ-016 HOLD, out_ready=1: clear out_valid at the edge and go to IDLE; no grant issued on that same edge.
REQ-017 HOLD, out_ready=0: hold out, out_id and out_valid stable; issue no grant.
REQ-018 Latency: gnt high in the cycle after req is sampled; out_valid high two cycles after req is sampled.
REQ-019 Throughput: at most one grant per 3 cycles.
REQ-020 gnt0 and gnt1 SHALL never be high together.
REQ-021 Requesters SHALL drop req in the gnt cycle; req still high in IDLE is a new request.
REQ-022 Requests are ignored in MUL and HOLD; req/operand changes there have no effect.
REQ-023 out and out_id SHALL keep their last value after out_valid clears.
REQ-024 Operand 0 on either side SHALL yield out=8'h00 with normal timing.

Reset
REQ-025 rst_n low SHALL immediately, independent of clk, force: state=IDLE, gnt0=gnt1=0, out=8'h00, out_valid=0, out_id=0, op_a=op_b=0, last_owner=1.
REQ-026 Reset in MUL or HOLD SHALL discard the pending result; the first grant after reset release needs a fresh req.

Configuration
REQ-027 Macro MULT_ARB_ROUND_ROBIN_EN defined: on simultaneous req0/req1 in IDLE, grant the requester not equal to last_owner; update last_owner on every grant.
REQ-028 Macro MULT_ARB_ROUND_ROBIN_EN undefined: fixed priority; req0 always wins a tie; last_owner unused.
REQ-029 A single request SHALL be granted the same way in both configurations.

Verification
REQ-030 Reset then idle 5 cycles -> out=0x00, out_valid=0, out_id=0, gnt0=gnt1=0 throughout.
REQ-031 req0 alone, a0=3, b0=5, out_ready=1 -> gnt0 pulse 1 cycle later; out=0x0F, out_valid=1, out_id=0 2 cycles after sampling; out_valid low after 1 cycle.
REQ-032 req0 (15x15) and req1 (2x7) both held until granted, RR enabled -> first out=0xE1 id 0, then out=0x0E id 1; without the macro and req0 re-raised each IDLE -> req1 never granted.
REQ-033 a0=9, b0=0 -> out=0x00, out_valid=1, id 0 at normal latency.
REQ-034 Result 0x0F in HOLD, out_ready=0 for 3 cycles, req1 high -> out/out_valid/out_id stable, no gnt1; out_ready=1 -> IDLE, then gnt1 on the following edge.
REQ-035 rst_n pulsed low mid-cycle in MUL -> out=0x00, out_valid=0, gnt low before the next clk edge; no stale result after release.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// Two requesters share one registered 4x4 multiplier through an IDLE/MUL/HOLD FSM.
// Optional build macro MULT_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking (default: req0 priority).

module fourbit_multiplier (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  assign p = {4'b0000, a} * {4'b0000, b};
endmodule

module mult_share_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  output logic       gnt0,
  input  logic       req1,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  output logic       gnt1,
  output logic [7:0] out,
  output logic       out_valid,
  output logic       out_id,
  input  logic       out_ready,
  output logic [1:0] fsm_state
);

  // Handshake: a requester holds reqN until it sees a one-cycle gntN pulse, at which point its
  // operands are already captured. out is offered while out_valid=1 and consumed on a cycle
  // where out_ready=1; out and out_id stay put until the next result replaces them.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t     state, state_d;
  logic       grant, load_out, clr_valid;
  logic       pick;
  logic       owner;
  logic [3:0] op_a, op_b;
  logic [7:0] prod;

  assign fsm_state = state;

  fourbit_multiplier u_mul (
    .a (op_a),
    .b (op_b),
    .p (prod)
  );

`ifdef MULT_ARB_ROUND_ROBIN_EN
  logic last_owner;

  // On a tie the requester that was not served last wins.
  assign pick = req1 & (~req0 | ~last_owner);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner <= 1'b1;
    end else if (grant) begin
      last_owner <= pick;
    end
  end
`else
  assign pick = req1 & ~req0;
`endif

  always_comb begin
    state_d   = state;
    grant     = 1'b0;
    load_out  = 1'b0;
    clr_valid = 1'b0;
    case (state)
      IDLE: begin
        if (req0 | req1) begin
          grant   = 1'b1;
          state_d = MUL;
        end
      end
      MUL: begin
        load_out = 1'b1;
        state_d  = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          clr_valid = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      op_a      <= 4'h0;
      op_b      <= 4'h0;
      owner     <= 1'b0;
      out       <= 8'h00;
      out_valid <= 1'b0;
      out_id    <= 1'b0;
    end else begin
      state <= state_d;
      gnt0  <= grant & ~pick;
      gnt1  <= grant & pick;
      if (grant) begin
        op_a  <= pick ? a1 : a0;
        op_b  <= pick ? b1 : b0;
        owner <= pick;
      end
      if (load_out) begin
        out       <= prod;
        out_valid <= 1'b1;
        out_id    <= owner;
      end else if (clr_valid) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
